// File: rtl/alu_exec_sequencer_if.sv
// Instruction channel between the issuing agent and alu_exec_sequencer.
interface alu_exec_sequencer_if;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_exec_sequencer.sv
// Four-phase (IDLE/READ/EXEC/WB) controller feeding a combinational 8-bit ALU from a 4x8 register file.
// Optional `zero` result flag is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_exec_sequencer (
  input  logic                 clk,
  input  logic                 reset,
  alu_exec_sequencer_if.slave  ibus,
  input  logic                 ld_en,
  input  logic [1:0]           ld_addr,
  input  logic [7:0]           ld_data,
  input  logic [1:0]           dbg_addr,
  output logic [7:0]           dbg_data,
  output logic [7:0]           decoded_opcode,
  output logic [7:0]           data1,
  output logic [7:0]           data2,
  input  logic [7:0]           alu_out,
  input  logic                 alu_flag,
  output logic [7:0]           result,
  output logic                 flag,
  output logic                 done
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic                 zero
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t     state;
  logic [7:0] regs [4];
  logic [2:0] op;
  logic [1:0] dst;
  logic [1:0] src1;
  logic [1:0] src2;
  logic       accept;

  assign ibus.instr_ready = (state == IDLE) && !reset;
  assign accept           = ibus.instr_valid && ibus.instr_ready;
  assign dbg_data         = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      regs           <= '{default: '0};
      op             <= '0;
      dst            <= '0;
      src1           <= '0;
      src2           <= '0;
      decoded_opcode <= '0;
      data1          <= '0;
      data2          <= '0;
      result         <= '0;
      flag           <= 1'b0;
      done           <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero           <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A load on the accept edge lands before READ samples the operands.
          if (ld_en) regs[ld_addr] <= ld_data;
          if (accept) begin
            op    <= ibus.instr[8:6];
            dst   <= ibus.instr[5:4];
            src1  <= ibus.instr[3:2];
            src2  <= ibus.instr[1:0];
            state <= READ;
          end
        end
        READ: begin
          data1          <= regs[src1];
          data2          <= regs[src2];
          decoded_opcode <= 8'b1 << op;
          state          <= EXEC;
        end
        EXEC: begin
          result         <= alu_out;
          flag           <= alu_flag;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero           <= (alu_out == 8'h00);
`endif
          decoded_opcode <= '0;
          done           <= 1'b1;
          state          <= WB;
        end
        WB: begin
          regs[dst] <= result;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Scoreboard bench for alu_exec_sequencer: stimulus pushes expected results, a negedge monitor checks them.
module tb_alu_exec_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
  logic [7:0] decoded_opcode, data1, data2, alu_out, result;
  logic       alu_flag, flag, done;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       zero;
`endif

  alu_exec_sequencer_if ibus ();

  alu_exec_sequencer dut (
    .clk(clk), .reset(reset), .ibus(ibus),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .decoded_opcode(decoded_opcode), .data1(data1), .data2(data2),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .result(result), .flag(flag), .done(done)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the combinational ALU downstream of the sequencer.
  always_comb begin
    alu_out  = '0;
    alu_flag = 1'b0;
    case (decoded_opcode)
      8'h01: alu_out = data1 ^ data2;
      8'h02: {alu_flag, alu_out} = {1'b0, data1} + {1'b0, data2};
      8'h04: begin alu_out = data1 - data2; alu_flag = (data1 < data2); end
      8'h08: {alu_flag, alu_out} = {1'b0, data1} + 9'd1;
      8'h10: begin alu_out = data1 - 8'd1; alu_flag = (data1 == 8'h00); end
      8'h20: alu_out = data1 & data2;
      8'h40: alu_out = data1 | data2;
      8'h80: alu_out = ~data1;
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] onehot;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] res;
    logic       f;
    logic [1:0] dst;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mregs [4];

  // Reference semantics of each opcode on plain integers.
  function automatic void ref_exec(input int op, input int a, input int b,
                                   output logic [7:0] r, output logic f);
    int s;
    s = 0;
    case (op)
      0: s = a ^ b;
      1: s = a + b;
      2: s = a - b;
      3: s = a + 1;
      4: s = a - 1;
      5: s = a & b;
      6: s = a | b;
      default: s = 255 - a;
    endcase
    r = 8'(s);
    f = (op >= 1 && op <= 4) && (s < 0 || s > 255);
  endfunction

  // One clock: update the model from the inputs about to be sampled, then advance.
  task automatic cycle(output bit acc);
    bit   rst_now;
    exp_t e;
    int   op;
    acc     = 0;
    rst_now = reset;
    if (!reset && ibus.instr_ready) begin
      if (ld_en) mregs[ld_addr] = ld_data;
      if (ibus.instr_valid) begin
        op       = int'(ibus.instr[8:6]);
        e.dst    = ibus.instr[5:4];
        e.d1     = mregs[ibus.instr[3:2]];
        e.d2     = mregs[ibus.instr[1:0]];
        e.onehot = 8'(2 ** op);
        ref_exec(op, int'(e.d1), int'(e.d2), e.res, e.f);
        e.acc    = cyc;
        mregs[e.dst] = e.res;
        exp_q.push_back(e);
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                       input logic [1:0] s2);
    bit a;
    a = 0;
    ibus.instr_valid = 1'b1;
    ibus.instr       = {op, d, s1, s2};
    for (int i = 0; i < 10 && !a; i++) cycle(a);
    ibus.instr_valid = 1'b0;
    if (!a) chk("accept_timeout", 0, 1);
    for (int i = 0; i < 10 && !ibus.instr_ready; i++) cycle(a);
    if (!ibus.instr_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    bit x;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    cycle(x);
    ld_en = 1'b0;
  endtask

  logic       dbg_sel = 1'b0;
  logic [1:0] stim_addr = '0;
  logic [1:0] mon_addr = '0;
  assign dbg_addr = dbg_sel ? stim_addr : mon_addr;

  task automatic dbg_chk(input string name, input logic [1:0] a, input logic [7:0] v);
    bit x;
    cycle(x);
    dbg_sel = 1'b1; stim_addr = a;
    #1;
    chk(name, dbg_data, v);
    dbg_sel = 1'b0;
  endtask

  // Monitor: operands in EXEC, result/flag on done, register contents one cycle later.
  initial begin
    exp_t       e;
    bit         pend = 0;
    logic [7:0] pend_val = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("reg_writeback", dbg_data, pend_val);
        pend = 0;
      end
      if (decoded_opcode !== 8'h00) begin
        if (exp_q.size() == 0) chk("unexpected_exec", decoded_opcode, 0);
        else begin
          e = exp_q[0];
          chk("decoded_opcode", decoded_opcode, e.onehot);
          chk("data1", data1, e.d1);
          chk("data2", data2, e.d2);
          chk("exec_timing", cyc, e.acc + 2);
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_done", done, 0);
        else begin
          e = exp_q.pop_front();
          chk("result", result, e.res);
          chk("flag", flag, e.f);
          chk("done_timing", cyc, e.acc + 3);
`ifdef ALU_SEQ_ZERO_FLAG_EN
          chk("zero", zero, e.res == 8'h00);
`endif
          mon_addr = e.dst;
          pend     = 1;
          pend_val = e.res;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit x;
    int prev;
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    ibus.instr_valid = 1'b0; ibus.instr = '0;
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    @(posedge clk); #1;
    cycle(x); cycle(x);
    chk("rst_ready", ibus.instr_ready, 0);
    chk("rst_decoded", decoded_opcode, 0);
    chk("rst_data1", data1, 0);
    chk("rst_data2", data2, 0);
    chk("rst_result", result, 0);
    chk("rst_flag", flag, 0);
    chk("rst_done", done, 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    chk("rst_zero", zero, 0);
`endif
    reset = 1'b0;
    #1 chk("ready_after_rst", ibus.instr_ready, 1);

    // Arithmetic with carry/borrow corner values.
    load(0, 8'hFF); load(1, 8'h01);
    issue(3'd1, 2, 0, 1); chk("add_res", result, 8'h00); chk("add_flag", flag, 1);
    dbg_chk("add_r2", 2, 8'h00);
    issue(3'd2, 3, 1, 0); chk("sub_res", result, 8'h02); chk("sub_flag", flag, 1);
    issue(3'd4, 0, 2, 2); chk("dec_res", result, 8'hFF); chk("dec_flag", flag, 1);
    issue(3'd3, 1, 0, 0); chk("inc_res", result, 8'h00); chk("inc_flag", flag, 1);

    // Logic ops.
    load(0, 8'hA5); load(1, 8'h3C);
    issue(3'd0, 2, 0, 1); chk("xor_res", result, 8'h99); chk("xor_flag", flag, 0);
    issue(3'd5, 2, 0, 1); chk("and_res", result, 8'h24); chk("and_flag", flag, 0);
    issue(3'd6, 2, 0, 1); chk("or_res", result, 8'hBD); chk("or_flag", flag, 0);
    issue(3'd7, 2, 0, 1); chk("not_res", result, 8'h5A); chk("not_flag", flag, 0);

    // Load coinciding with accept, then loads while busy must be dropped.
    ld_en = 1'b1; ld_addr = 1; ld_data = 8'h77;
    ibus.instr_valid = 1'b1; ibus.instr = {3'd1, 2'd2, 2'd1, 2'd1};
    cycle(x);
    chk("accept_with_load", x, 1);
    ibus.instr_valid = 1'b0;
    ld_addr = 0; ld_data = 8'h11;
    cycle(x); cycle(x); cycle(x);
    ld_en = 1'b0;
    chk("ld_ovl_res", result, 8'hEE);
    dbg_chk("ld_busy_r0", 0, 8'hA5);
    dbg_chk("ld_ovl_r2", 2, 8'hEE);

    // Back-to-back offers with random loads: accepts every 4 cycles.
    prev = -1;
    ibus.instr_valid = 1'b1;
    ibus.instr = 9'($urandom);
    for (int i = 0; i < 240; i++) begin
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 2'($urandom);
      ld_data = 8'($urandom);
      cycle(x);
      if (x) begin
        if (prev >= 0) chk("accept_spacing", cyc - 1 - prev, 4);
        prev = cyc - 1;
        ibus.instr = 9'($urandom);
      end
    end
    ibus.instr_valid = 1'b0; ld_en = 1'b0;
    for (int i = 0; i < 10 && !ibus.instr_ready; i++) cycle(x);

    // Random traffic with gaps.
    for (int i = 0; i < 300; i++) begin
      ibus.instr_valid = ($urandom_range(0, 2) != 0);
      ibus.instr       = 9'($urandom);
      ld_en            = ($urandom_range(0, 2) == 0);
      ld_addr          = 2'($urandom);
      ld_data          = 8'($urandom);
      cycle(x);
    end
    ibus.instr_valid = 1'b0; ld_en = 1'b0;
    for (int i = 0; i < 10 && !ibus.instr_ready; i++) cycle(x);
    cycle(x);

    // Reset during EXEC: no writeback, everything cleared.
    load(0, 8'h12); load(1, 8'h34); load(2, 8'h56); load(3, 8'h78);
    ibus.instr_valid = 1'b1; ibus.instr = {3'd1, 2'd2, 2'd0, 2'd1};
    cycle(x);
    chk("rst_test_accept", x, 1);
    ibus.instr_valid = 1'b0;
    cycle(x);
    reset = 1'b1;
    #1 chk("ready_in_rst", ibus.instr_ready, 0);
    cycle(x); cycle(x);
    chk("midrst_result", result, 0);
    chk("midrst_flag", flag, 0);
    chk("midrst_decoded", decoded_opcode, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    #1 chk("ready_post_rst", ibus.instr_ready, 1);
    for (int i = 0; i < 4; i++) dbg_chk("midrst_regs", 2'(i), 8'h00);
    for (int i = 0; i < 6; i++) cycle(x);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
